// File: rtl/sign_to_twoc_serial.sv
// sign_to_twoc_serial: bit-serial sign-magnitude to two's-complement converter; optional neg_zero output under SM2TC_NEGZERO_FLAG_EN
module sign_to_twoc_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic         busy,
    output logic         done
`ifdef SM2TC_NEGZERO_FLAG_EN
    ,
    output logic         neg_zero
`endif
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        r_state, w_next;
    logic [N-1:0]  r_op, r_res, r_b;
    logic          r_s, r_carry;
    logic [CW-1:0] r_cnt;
    logic          w_accept, w_last, w_x, w_bit;

    // half-adder stage on the current bit; the sign position is forced to S so negative zero wraps to 0
    always_comb begin
        w_accept = start && (r_state == IDLE || r_state == DONE);
        w_last   = r_cnt == LAST;
        w_x      = w_last ? r_s : (r_op[0] ^ r_s);
        w_bit    = w_x ^ r_carry;
        w_next   = (r_state == RUN) ? (w_last ? DONE : RUN) : (w_accept ? RUN : IDLE);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // operand/result shift registers and carry; B only changes when the last bit lands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_res   <= '0;
            r_b     <= '0;
            r_s     <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_op    <= A;
            r_s     <= A[N-1];
            r_carry <= A[N-1];
            r_cnt   <= '0;
            r_res   <= '0;
        end else if (r_state == RUN) begin
            r_op    <= r_op >> 1;
            r_carry <= w_x & r_carry;
            r_cnt   <= r_cnt + 1'b1;
            r_res   <= {w_bit, r_res[N-1:1]};
            if (w_last) r_b <= {w_bit, r_res[N-1:1]};
        end
    end

    assign B    = r_b;
    assign busy = r_state == RUN;
    assign done = r_state == DONE;

`ifdef SM2TC_NEGZERO_FLAG_EN
    logic r_nz;

    // remember whether the accepted operand was negative zero; flag shows only alongside done
    always_ff @(posedge clk) begin
        if (rst)           r_nz <= 1'b0;
        else if (w_accept) r_nz <= A[N-1] && (A[N-2:0] == '0);
    end

    assign neg_zero = done && r_nz;
`endif
endmodule

// File: doc/sign_to_twoc_serial.md
Name: sign_to_twoc_serial

Overview:
- Bit-serial converter from sign-magnitude to two's complement, the inverse of the calculator's two's-complement-to-sign-magnitude path.
- Sits between the operand entry / display formatting logic and the ALU, so signed operands entered in sign-magnitude reach the adder in two's complement.
- Resolves one bit per clock with a single half-adder stage and a carry register.
- Start/busy/done handshake to the calculator control FSM.

Parameters:
- N, 8, operand width in bits (MSB = sign, bits N-2..0 = magnitude); legal N >= 2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request a conversion; sampled only in IDLE or DONE
- A  input  N  sign-magnitude operand; captured on an accepted start
- B  output  N  two's-complement result; valid while done=1 and held until the next accepted start
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse; result valid

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst. All state changes on the rising edge of clk; no asynchronous paths.
- Reset: state=IDLE, B=0, busy=0, done=0, carry=0, bit counter=0, shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: capture A into the operand register, capture S=A[N-1], load carry=S, clear the bit counter and result register, then go to RUN. busy=1 from the next cycle.
- RUN, bit i where i is 0..N-1, one bit per cycle:
  - x = A[i]^S for i < N-1; x = S for i = N-1 (the top magnitude bit is treated as 0 before inversion).
  - Result bit i = x ^ carry; then carry <= x & carry.
  - After bit N-1 is written, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, with B = assembled result. Next state is IDLE.
  - A start in DONE is accepted exactly as in IDLE, giving back-to-back conversions with no idle cycle.
- Latency: start accepted at edge 0, bits written at edges 1..N, done high in the cycle after edge N. That is N+1 cycles from start to done, and a throughput of one conversion per N+1 cycles.
- Arithmetic:
  - S=0: B = A, with B[N-1]=0.
  - S=1, magnitude M != 0: B = 2^N - M, with B[N-1]=1.
  - Negative zero (S=1, M=0): B = 0, because the carry propagates through every bit so B[N-1] = S^1 = 0.
  - The most negative two's-complement value (-2^(N-1)) is never produced; there is no overflow case.
- B is updated only at DONE entry (result register copied to B). B does not change during RUN, so downstream logic sees a stable previous result.
- start while in RUN: ignored. No queuing and no error flag. A changing during RUN has no effect because the operand is registered.
- rst during RUN or DONE: returns to IDLE with all outputs at reset values in the next cycle. A partial result is discarded and no done pulse is produced.
- start and rst in the same cycle: rst wins.

Optional Feature:
- Macro: SM2TC_NEGZERO_FLAG_EN.
- Defined:
  - Adds output neg_zero (1 bit), asserted coincident with done when the captured operand was negative zero (S=1, M=0). Low otherwise.
  - neg_zero resets to 0. Its timing and clearing match done exactly.
- Undefined: the neg_zero port and its logic are absent. All other behaviour is identical.

Test Plan:
- N=8, A=8'h05 (+5), start pulse -> done 9 cycles later, B=8'h05, busy high for the 8 RUN cycles.
- A=8'h85 (-5) -> B=8'hFB. A=8'hFF (-127) -> B=8'h81. A=8'h81 (-1) -> B=8'hFF.
- A=8'h80 (negative zero) -> B=8'h00. With SM2TC_NEGZERO_FLAG_EN, neg_zero=1 with done. A=8'h00 -> B=8'h00, neg_zero=0.
- Start A=8'h85, then hold start=1 with A=8'h03 during RUN -> that start is ignored, B=8'hFB. A new start in the DONE cycle with A=8'h83 -> the next done gives B=8'hFD with no idle cycle between conversions.
- Start A=8'h85, assert rst at the 4th RUN cycle -> next cycle B=0, busy=0, done=0, and no done pulse follows. A later start with A=8'h02 -> B=8'h02.
- Parameter N=4: A=4'hD (-5) -> B=4'hB after 5 cycles. A=4'h8 -> B=4'h0.
